// File: rtl/jesd_rx_sync_ctrl.sv
// JESD204B receive-side SYNC~ controller: per-lane CGS tracking, SYSREF-aligned
// LMFC counter, and the SYNC~ release and error-pulse reporting state machine.
module jesd_rx_sync_ctrl #(
  parameter int LANES       = 4,
  parameter int K_COUNT     = 4,
  parameter int LMFC_PERIOD = 32,
  parameter int ERR_PULSE   = 2,
  parameter int ERR_THRESH  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             link_en,
  input  logic             sysref,
  input  logic [LANES-1:0] lane_valid,
  input  logic [LANES-1:0] lane_k285,
  input  logic [LANES-1:0] lane_err,
  output logic             sync_n,
  output logic             lmfc_edge,
  output logic             cgs_done,
  output logic             link_up,
  output logic [15:0]      err_cnt,
  output logic [1:0]       state
);

  localparam int LW = (LMFC_PERIOD > 1) ? $clog2(LMFC_PERIOD) : 1;
  localparam int KW = $clog2(K_COUNT + 1);
  localparam int PW = $clog2(ERR_PULSE + 1);
  localparam int CW = $clog2(LANES + 1);
  localparam logic [LW-1:0] LMFC_LAST = LW'(LMFC_PERIOD - 1);
  localparam logic [KW-1:0] K_MAX     = KW'(K_COUNT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CGS       = 2'd1,
    WAIT_LMFC = 2'd2,
    DATA      = 2'd3
  } state_t;

  state_t          cur_state;
  logic [LW-1:0]   lmfc_cnt;
  logic            sysref_d;
  logic            sysref_rise;
  logic [KW-1:0]   k_cnt [LANES];
  logic            all_k;
  logic [PW-1:0]   pulse_cnt;
  logic [CW-1:0]   err_hits;
  logic [16:0]     err_sum;
  logic [15:0]     err_next;
  logic            thresh_hit;
  logic            enter_cgs;

  assign sysref_rise = sysref & ~sysref_d;
  assign lmfc_edge   = (lmfc_cnt == '0);
  assign cgs_done    = (cur_state == WAIT_LMFC) || (cur_state == DATA);
  assign link_up     = (cur_state == DATA);
  assign state       = cur_state;

  // A SYSREF rising edge realigns the multiframe counter regardless of state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lmfc_cnt <= '0;
      sysref_d <= 1'b0;
    end else begin
      sysref_d <= sysref;
      if (sysref_rise || (lmfc_cnt == LMFC_LAST))
        lmfc_cnt <= '0;
      else
        lmfc_cnt <= lmfc_cnt + LW'(1);
    end
  end

  always_comb begin
    err_hits = '0;
    all_k    = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      err_hits = err_hits + CW'(lane_valid[i] & lane_err[i]);
      if (k_cnt[i] != K_MAX) all_k = 1'b0;
    end
  end

  assign err_sum    = {1'b0, err_cnt} + {{(17-CW){1'b0}}, err_hits};
  assign err_next   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  assign thresh_hit = (err_next >= 16'(ERR_THRESH));

  assign enter_cgs = link_en &&
                     ((cur_state == IDLE) ||
                      ((cur_state == WAIT_LMFC) && !all_k) ||
                      ((cur_state == DATA) && thresh_hit));

  // Consecutive clean K28.5 run length per lane, restarted on every CGS entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) k_cnt[i] <= '0;
    end else if (enter_cgs) begin
      for (int i = 0; i < LANES; i++) k_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_valid[i]) begin
          if (lane_k285[i] && !lane_err[i]) begin
            if (k_cnt[i] != K_MAX) k_cnt[i] <= k_cnt[i] + KW'(1);
          end else begin
            k_cnt[i] <= '0;
          end
        end
      end
    end
  end

  // Link FSM; dropping link_en overrides every other transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
      sync_n    <= 1'b0;
      err_cnt   <= '0;
      pulse_cnt <= '0;
    end else if (!link_en) begin
      cur_state <= IDLE;
      sync_n    <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      case (cur_state)
        IDLE: begin
          cur_state <= CGS;
          sync_n    <= 1'b0;
          err_cnt   <= '0;
          pulse_cnt <= '0;
        end
        CGS: begin
          sync_n <= 1'b0;
          if (all_k) cur_state <= WAIT_LMFC;
        end
        WAIT_LMFC: begin
          sync_n <= 1'b0;
          if (!all_k) begin
            cur_state <= CGS;
            err_cnt   <= '0;
          end else if (lmfc_edge) begin
            cur_state <= DATA;
            sync_n    <= 1'b1;
            pulse_cnt <= '0;
          end
        end
        DATA: begin
          if (thresh_hit) begin
            cur_state <= CGS;
            sync_n    <= 1'b0;
            pulse_cnt <= '0;
            err_cnt   <= '0;
          end else begin
            err_cnt <= err_next;
            if (pulse_cnt == '0) begin
              if (err_hits != '0) begin
                pulse_cnt <= PW'(ERR_PULSE);
                sync_n    <= 1'b0;
              end else begin
                sync_n <= 1'b1;
              end
            end else begin
              pulse_cnt <= pulse_cnt - PW'(1);
              sync_n    <= (pulse_cnt == PW'(1));
            end
          end
        end
        default: begin
          cur_state <= IDLE;
          sync_n    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jesd_rx_sync_ctrl.sv
// Bench for jesd_rx_sync_ctrl: directed link scenarios plus randomized traffic,
// all outputs compared every cycle against a rule-level reference model.
module tb_jesd_rx_sync_ctrl;

  localparam int LANES       = 4;
  localparam int K_COUNT     = 4;
  localparam int LMFC_PERIOD = 32;
  localparam int ERR_PULSE   = 2;
  localparam int ERR_THRESH  = 8;
  localparam int S_IDLE = 0, S_CGS = 1, S_WAIT = 2, S_DATA = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             link_en = 1'b0;
  logic             sysref = 1'b0;
  logic [LANES-1:0] lane_valid = '0;
  logic [LANES-1:0] lane_k285 = '0;
  logic [LANES-1:0] lane_err = '0;
  logic             sync_n, lmfc_edge, cgs_done, link_up;
  logic [15:0]      err_cnt;
  logic [1:0]       state;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  jesd_rx_sync_ctrl #(
    .LANES(LANES), .K_COUNT(K_COUNT), .LMFC_PERIOD(LMFC_PERIOD),
    .ERR_PULSE(ERR_PULSE), .ERR_THRESH(ERR_THRESH)
  ) dut (
    .clk(clk), .reset(reset), .link_en(link_en), .sysref(sysref),
    .lane_valid(lane_valid), .lane_k285(lane_k285), .lane_err(lane_err),
    .sync_n(sync_n), .lmfc_edge(lmfc_edge), .cgs_done(cgs_done),
    .link_up(link_up), .err_cnt(err_cnt), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: link state, multiframe phase, error total, remaining
  // SYNC~ low cycles and per-lane clean-K run length, as plain integers.
  int m_state = S_IDLE, m_phase = 0, m_err = 0, m_pulse = 0;
  int m_run [LANES] = '{default: 0};
  bit m_sysref_prev = 1'b0;
  int t_hits, t_total, t_state, t_err, t_pulse;
  bit t_allk, t_enter;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state <= S_IDLE; m_phase <= 0; m_err <= 0; m_pulse <= 0;
      m_sysref_prev <= 1'b0;
      for (int i = 0; i < LANES; i++) m_run[i] <= 0;
    end else begin
      t_hits = 0;
      t_allk = 1'b1;
      for (int i = 0; i < LANES; i++) begin
        if (lane_valid[i] && lane_err[i]) t_hits++;
        if (m_run[i] < K_COUNT) t_allk = 1'b0;
      end
      t_state = m_state;
      t_err   = m_err;
      t_pulse = (m_pulse > 0) ? m_pulse - 1 : 0;
      t_enter = 1'b0;
      if (!link_en) begin
        t_state = S_IDLE;
        t_pulse = 0;
      end else if (m_state == S_IDLE) begin
        t_state = S_CGS; t_enter = 1'b1;
      end else if (m_state == S_CGS) begin
        if (t_allk) t_state = S_WAIT;
      end else if (m_state == S_WAIT) begin
        if (!t_allk) begin t_state = S_CGS; t_enter = 1'b1; end
        else if (m_phase == 0) begin t_state = S_DATA; t_pulse = 0; end
      end else begin
        t_total = m_err + t_hits;
        if (t_total > 65535) t_total = 65535;
        if (t_total >= ERR_THRESH) begin
          t_state = S_CGS; t_enter = 1'b1;
        end else begin
          t_err = t_total;
          if (m_pulse == 0 && t_hits > 0) t_pulse = ERR_PULSE;
        end
      end
      if (t_enter) begin t_err = 0; t_pulse = 0; end
      for (int i = 0; i < LANES; i++) begin
        if (t_enter) m_run[i] <= 0;
        else if (lane_valid[i])
          m_run[i] <= (lane_k285[i] && !lane_err[i]) ?
                      ((m_run[i] < K_COUNT) ? m_run[i] + 1 : K_COUNT) : 0;
      end
      m_phase <= (sysref && !m_sysref_prev) ? 0 : (m_phase + 1) % LMFC_PERIOD;
      m_sysref_prev <= sysref;
      m_state <= t_state;
      m_err   <= t_err;
      m_pulse <= t_pulse;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // SYNC~ is low everywhere except in DATA outside an error pulse.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model state", int'(state), m_state);
      checkOutput("model sync_n", int'(sync_n), (m_state == S_DATA && m_pulse == 0) ? 1 : 0);
      checkOutput("model lmfc_edge", int'(lmfc_edge), (m_phase == 0) ? 1 : 0);
      checkOutput("model cgs_done", int'(cgs_done), (m_state >= S_WAIT) ? 1 : 0);
      checkOutput("model link_up", int'(link_up), (m_state == S_DATA) ? 1 : 0);
      checkOutput("model err_cnt", int'(err_cnt), m_err);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit en, input bit sr, input logic [LANES-1:0] vld,
                               input logic [LANES-1:0] k, input logic [LANES-1:0] err);
    link_en = en; sysref = sr; lane_valid = vld; lane_k285 = k; lane_err = err;
  endtask

  task automatic waitLinkUp(input int max_cycles, output int n);
    n = 0;
    while (!link_up && n < max_cycles) begin
      tick();
      n++;
    end
    checkOutput("link_up reached", int'(link_up), 1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [LANES-1:0] rv, rk, re;
    applyStimulus(0, 0, '0, '0, '0);
    repeat (3) tick();
    check_en = 1'b1;
    checkOutput("reset state", int'(state), S_IDLE);
    checkOutput("reset sync_n", int'(sync_n), 0);
    checkOutput("reset err_cnt", int'(err_cnt), 0);
    checkOutput("reset lmfc_edge", int'(lmfc_edge), 1);
    reset = 1'b0;

    // Bring-up: SYSREF realigns at edge 2, CGS done after 4 K chars.
    applyStimulus(1, 0, '1, '1, '0);
    tick(); checkOutput("bringup CGS", int'(state), S_CGS);
    applyStimulus(1, 1, '1, '1, '0);
    tick(); checkOutput("sysref realign", int'(lmfc_edge), 1);
    applyStimulus(1, 0, '1, '1, '0);
    repeat (3) tick();
    checkOutput("still CGS", int'(state), S_CGS);
    tick(); checkOutput("enter WAIT", int'(state), S_WAIT);
    waitLinkUp(100, n);
    checkOutput("LMFC wait cycles", n, 29);
    checkOutput("sync released", int'(sync_n), 1);

    // Single error then a second error during the pulse.
    applyStimulus(1, 0, '1, '1, 4'b0001);
    tick(); checkOutput("pulse start", int'(sync_n), 0);
    checkOutput("err_cnt one", int'(err_cnt), 1);
    applyStimulus(1, 0, '1, '1, 4'b0010);
    tick(); checkOutput("pulse second", int'(sync_n), 0);
    applyStimulus(1, 0, '1, '1, '0);
    tick(); checkOutput("pulse end", int'(sync_n), 1);
    checkOutput("err_cnt two", int'(err_cnt), 2);
    checkOutput("still DATA", int'(state), S_DATA);

    // Burst on all lanes crosses the threshold.
    applyStimulus(1, 0, '1, '1, '1);
    tick(); checkOutput("err_cnt six", int'(err_cnt), 6);
    checkOutput("DATA below thresh", int'(state), S_DATA);
    tick(); checkOutput("thresh resync", int'(state), S_CGS);
    checkOutput("thresh err clear", int'(err_cnt), 0);
    checkOutput("thresh sync_n", int'(sync_n), 0);
    applyStimulus(1, 0, '1, '1, '0);
    waitLinkUp(200, n);

    // link_en drop with coincident SYSREF.
    applyStimulus(0, 1, '1, '1, '0);
    tick(); checkOutput("drop IDLE", int'(state), S_IDLE);
    checkOutput("drop lmfc_edge", int'(lmfc_edge), 1);
    applyStimulus(0, 0, '1, '1, '0);
    repeat (5) tick();
    checkOutput("held IDLE", int'(state), S_IDLE);

    // Lane 2 glitch after 3 K chars restarts its run.
    applyStimulus(1, 0, '1, '1, '0);
    tick(); checkOutput("reenter CGS", int'(state), S_CGS);
    repeat (3) tick();
    applyStimulus(1, 0, '1, 4'b1011, '0);
    tick();
    applyStimulus(1, 0, '1, '1, '0);
    repeat (4) tick();
    checkOutput("glitch still CGS", int'(state), S_CGS);
    tick(); checkOutput("glitch WAIT", int'(state), S_WAIT);
    waitLinkUp(100, n);

    // Asynchronous reset in the middle of an error pulse.
    applyStimulus(1, 0, '1, '1, 4'b1000);
    tick(); checkOutput("pre-reset pulse", int'(sync_n), 0);
    #2 reset = 1'b1;
    #1;
    checkOutput("async sync_n", int'(sync_n), 0);
    checkOutput("async state", int'(state), S_IDLE);
    checkOutput("async err_cnt", int'(err_cnt), 0);
    checkOutput("async lmfc_edge", int'(lmfc_edge), 1);
    applyStimulus(1, 0, '1, '1, '0);
    repeat (2) tick();
    reset = 1'b0;
    waitLinkUp(200, n);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < LANES; i++) begin
        rv[i] = ($urandom_range(0, 7) != 0);
        rk[i] = ($urandom_range(0, 199) != 0);
        re[i] = ($urandom_range(0, 299) == 0);
      end
      applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 49) == 0), rv, rk, re);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jesd_rx_sync_ctrl.md
Name: jesd_rx_sync_ctrl

Overview:
- Receive-side JESD204B link controller that drives SYNC~ toward the ADC/transmitter; it is the counterpart of the tx_sync consumer on the DAC side.
- Monitors per-lane 8b10b decoder flags and runs code-group synchronisation (CGS).
- Releases SYNC~ on an LMFC boundary aligned to SYSREF, then reports errors with SYNC~ pulses.
- Its sync_n output feeds the rx_sync OBUFDS at top level.

Parameters:
LANES, 4, number of JESD lanes monitored
K_COUNT, 4, consecutive valid K28.5 characters required per lane to complete CGS (>=1)
LMFC_PERIOD, 32, clk cycles per local multiframe (>=2)
ERR_PULSE, 2, clk cycles sync_n is held low per error report (>=1)
ERR_THRESH, 8, accumulated lane errors in DATA that force a resync (>=1)

Ports:
clk  in  1  link/frame clock
reset  in  1  asynchronous, active-high reset
link_en  in  1  link enable; low forces IDLE
sysref  in  1  SYSREF, already synchronous to clk
lane_valid  in  LANES  per-lane decoded character valid
lane_k285  in  LANES  per-lane character is K28.5, qualified by lane_valid
lane_err  in  LANES  per-lane disparity/not-in-table error, qualified by lane_valid
sync_n  out  1  SYNC~ to transmitter, active low, registered
lmfc_edge  out  1  high while lmfc_cnt==0
cgs_done  out  1  high in WAIT_LMFC and DATA
link_up  out  1  high in DATA
err_cnt  out  16  saturating error count since last CGS entry
state  out  2  IDLE=0, CGS=1, WAIT_LMFC=2, DATA=3

Behaviour:
- Reset values: state=IDLE, sync_n=0, lmfc_cnt=0, err_cnt=0, all lane K counters=0, pulse counter=0, sysref_d=0.
- LMFC counter:
  - Counts 0..LMFC_PERIOD-1 and wraps to 0.
  - sysref_rise = sysref & ~sysref_d. On a rise, lmfc_cnt loads 0 at the next edge, overriding the increment.
  - Free-runs from reset before the first SYSREF. A SYSREF in any state realigns the counter and never changes state.
- Lane K counters:
  - Updated only on cycles where lane_valid[i]=1.
  - lane_k285 & ~lane_err increments the counter, saturating at K_COUNT. Any other valid character clears it to 0.
  - all_k = every lane counter == K_COUNT.
  - All counters are cleared on entry to CGS.
- FSM, all transitions registered:
  - IDLE: sync_n=0. If link_en=1, go to CGS next cycle.
  - CGS: sync_n=0. If all_k, go to WAIT_LMFC.
  - WAIT_LMFC: sync_n=0.
    - If all_k drops, return to CGS.
    - Otherwise, on a cycle with lmfc_cnt==0: state<=DATA, sync_n<=1 at the same edge.
    - If all_k and lmfc_cnt==0 occur in the same cycle as the CGS->WAIT_LMFC transition, wait for the next boundary. Minimum dwell in WAIT_LMFC is 1 cycle.
  - DATA: sync_n=1, except during an error pulse.
    - Each cycle, err_cnt += popcount(lane_valid & lane_err), saturating at 16'hFFFF.
    - Any error while the pulse counter is 0: load the pulse counter with ERR_PULSE. sync_n is low for exactly ERR_PULSE cycles starting the next edge.
    - Errors arriving during an active pulse neither extend nor retrigger it, but are still counted.
    - If the updated err_cnt >= ERR_THRESH, go to CGS next cycle with sync_n=0. The pulse counter is cleared and err_cnt is cleared on CGS entry.
- link_en=0 in any state: go to IDLE next cycle with sync_n=0. This has priority over every other transition.
- err_cnt is cleared on entry to CGS and holds its value in IDLE.
- lmfc_edge is combinational from the lmfc_cnt register.
- cgs_done and link_up are decoded from the state register.
- Asynchronous reset mid-operation: all registers return to their reset values immediately, and sync_n goes low without waiting for a clock edge.

Test Plan:
- Reset, link_en=1, all 4 lanes send valid K28.5 continuously, sysref pulse at cycle 10 -> state IDLE->CGS->WAIT_LMFC after 4 K chars; sync_n rises on the edge where lmfc_cnt==0 (32 cycles after the sysref realign); link_up=1.
- Lane 2 sends one non-K valid character after 3 K chars, others keep sending K -> lane 2 counter clears, and WAIT_LMFC is entered only 4 valid K chars after the glitch.
- In DATA, a single lane_err on lane 0 -> sync_n low for exactly 2 cycles starting one cycle later; err_cnt=1; state stays DATA.
- In DATA, lane_err on all 4 lanes for 2 consecutive cycles -> err_cnt reaches 8 >= ERR_THRESH; state=CGS next cycle, sync_n=0, err_cnt=0.
- Drop link_en during DATA while a sysref arrives in the same cycle -> state=IDLE next cycle, sync_n=0, lmfc_cnt=0; no DATA re-entry until link_en=1 and CGS completes again.
- Assert reset mid-error-pulse -> sync_n=0, state=IDLE, err_cnt=0, all counters 0 asynchronously; after release, the full sequence completes normally.
